test_status_reporter: RTL and testbench
=======================================

Name: test_status_reporter

Overview:
- Wishbone-slave peripheral in the user project that generates the test-status signals on the GPIO pins that the chip-level test benches monitor: success level on mprj_io[12] and a next-test strobe on mprj_io[13].
- Firmware writes pass/fail results into a 4-entry FIFO.
- A sequencer replays each result as a setup / pulse / gap waveform. success_o is always stable before next_test_o rises.
- Also keeps test and fail counters plus sticky error flags for firmware readback.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; must be a power of two, minimum 2.
- SETUP_CYCLES, 2, cycles success_o is held before next_test_o rises; minimum 1.
- DEFAULT_PULSE, 8, reset value of CONFIG.pulse_len.
- DEFAULT_GAP, 16, reset value of CONFIG.gap_len.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  strobe; block selected by parent decode
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte lane selects
- wb_adr_i  in  4  byte address; bits [3:2] select the register
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  acknowledge
- wb_dat_o  out  32  read data
- success_o  out  1  current result level, to mprj_io[12]
- next_test_o  out  1  result strobe, to mprj_io[13]
- busy_o  out  1  high when the sequencer is not idle or the FIFO is not empty

Behaviour:
- Reset: async assert clears all of the following immediately, mid-waveform included:
  - outputs wb_ack_o, wb_dat_o, success_o, next_test_o, busy_o go to 0;
  - the FIFO is emptied and the FSM returns to IDLE;
  - counters and sticky flags are cleared;
  - CONFIG returns to its defaults.
- Wishbone handshake:
  - wb_ack_o pulses high for exactly one cycle, one cycle after a cycle with cyc&stb&!ack.
  - Every access is acked, including unmapped bits; there is no wait state beyond that.
  - The write side-effect occurs on the cycle in which ack is registered.
  - wb_dat_o is valid while ack is high and is 0 otherwise.
- Register 0x0 RESULT:
  - Write with sel[0]=1 pushes wb_dat_i[0] (1=pass).
  - If the FIFO is full and there is no pop in the same cycle, the data is dropped and sticky overflow is set.
  - Push and pop in the same cycle: the push is accepted.
  - Read returns {27'b0, overflow, count[2:0], busy}.
- Register 0x4 COUNTS (read-only): {fail_count[15:0], test_count[15:0]}. Both counters saturate at 0xFFFF.
- Register 0x8 CONFIG (RW, byte lanes honoured):
  - [7:0] pulse_len; 0 is treated as 1.
  - [15:8] gap_len; 0 means no gap.
  - Upper bits read 0.
- Register 0xC CLEAR:
  - Write with sel[0]=1 and bit0=1 zeroes both counters and the overflow flag.
  - If a clear coincides with a pop, the clear wins and the popped result is not counted.
  - Read returns {31'b0, any_fail}, where any_fail = fail_count != 0.
- FSM states IDLE, SETUP, PULSE, GAP:
  - IDLE, FIFO non-empty: pop, set success_o to the popped bit, increment test_count (and fail_count if the bit is 0), go to SETUP.
  - SETUP: after SETUP_CYCLES cycles, set next_test_o=1 and go to PULSE.
  - PULSE: after pulse_len cycles, set next_test_o=0; go to GAP, or straight to IDLE if gap_len=0.
  - GAP: after gap_len cycles, go to IDLE.
  - success_o holds its value until the next pop. It never changes while next_test_o=1.
- CONFIG timing: lengths are sampled on entry to each state, so a CONFIG write mid-waveform affects only later states.
- Minimum result period: 1 + SETUP_CYCLES + pulse_len + gap_len cycles.

Test Plan:
- Reset then read: 0x8 reads 0x00001008; 0x0 reads 0; success_o=0 and next_test_o=0.
- Write RESULT=1 (defaults): success_o=1 one cycle after the pop; next_test_o rises 2 cycles later and stays high 8 cycles; busy_o falls after a 16-cycle gap; COUNTS reads 0x00000001.
- Burst-write results 1,0,1,0,1 with no idle time and an outputs-silent window:
  - first 5 pushes are accepted (one pop frees a slot);
  - 6th push while full sets overflow;
  - five next_test_o pulses occur, with success_o sampled at each rise = 1,0,1,0,1;
  - COUNTS reads 0x00020005.
- CONFIG=0x0000 then write RESULT=0: next_test_o is high exactly 1 cycle; FSM returns to IDLE the next cycle; CLEAR read returns 1.
- Assert wb_rst_i during PULSE: next_test_o and success_o drop asynchronously; FIFO count reads 0 after release; no further pulses occur.
- Write CLEAR=1 on the same cycle a pop occurs: COUNTS reads 0; overflow reads 0.

Source files
------------

// File: rtl/test_status_reporter.sv
// rtl/test_status_reporter.sv - Wishbone test-status peripheral driving the success level and next-test strobe.
// Firmware queues pass/fail results; a sequencer replays each as setup / pulse / gap on the GPIO pins.
module test_status_reporter #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int DEFAULT_PULSE = 8,
  parameter int DEFAULT_GAP   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        success_o,
  output logic        next_test_o,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP} state_t;

  logic                  ack_q;
  logic [31:0]           dat_q;
  logic [FIFO_DEPTH-1:0] fifo_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q;
  logic [15:0]           test_cnt_q, fail_cnt_q;
  logic [7:0]            pulse_q, gap_q;
  state_t                state_q;
  logic [7:0]            timer_q;
  logic                  success_q, next_q, busy_q;

  logic        access, wr, push_req, push, pop, full, clr, pop_bit;
  logic [1:0]  reg_sel;
  logic [7:0]  pulse_eff;
  logic [2:0]  count3;
  logic [31:0] rdata_d;
  logic        unused_bits;

  assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = access & wb_we_i;
  assign reg_sel   = wb_adr_i[3:2];
  assign push_req  = wr && (reg_sel == 2'd0) && wb_sel_i[0];
  assign clr       = wr && (reg_sel == 2'd3) && wb_sel_i[0] && wb_dat_i[0];
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push      = push_req && (!full || pop);
  assign pop_bit   = fifo_q[rd_ptr_q];
  assign pulse_eff = (pulse_q == 8'd0) ? 8'd1 : pulse_q;
  assign count3    = 3'(count_q);
  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  always_comb begin
    rdata_d = 32'd0;
    case (reg_sel)
      2'd0: rdata_d = {27'd0, overflow_q, count3, busy_q};
      2'd1: rdata_d = {fail_cnt_q, test_cnt_q};
      2'd2: rdata_d = {16'd0, gap_q, pulse_q};
      2'd3: rdata_d = {31'd0, fail_cnt_q != 16'd0};
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= access;
      dat_q <= access ? rdata_d : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= wb_dat_i[0];
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (clr)
        overflow_q <= 1'b0;
      else if (push_req && !push)
        overflow_q <= 1'b1;
    end
  end

  // A clear coinciding with a pop wins: the popped result goes uncounted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      test_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else if (clr) begin
      test_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else if (pop) begin
      if (test_cnt_q != 16'hFFFF)
        test_cnt_q <= test_cnt_q + 16'd1;
      if (!pop_bit && (fail_cnt_q != 16'hFFFF))
        fail_cnt_q <= fail_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pulse_q <= 8'(DEFAULT_PULSE);
      gap_q   <= 8'(DEFAULT_GAP);
    end else if (wr && (reg_sel == 2'd2)) begin
      if (wb_sel_i[0])
        pulse_q <= wb_dat_i[7:0];
      if (wb_sel_i[1])
        gap_q <= wb_dat_i[15:8];
    end
  end

  // Lengths are loaded into the timer on state entry, so CONFIG writes only affect later states.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      timer_q   <= 8'd0;
      success_q <= 1'b0;
      next_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            success_q <= pop_bit;
            state_q   <= S_SETUP;
            timer_q   <= 8'(SETUP_CYCLES - 1);
          end else begin
            busy_q <= (count_d != '0);
          end
        end
        S_SETUP: begin
          if (timer_q == 8'd0) begin
            next_q  <= 1'b1;
            state_q <= S_PULSE;
            timer_q <= pulse_eff - 8'd1;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        S_PULSE: begin
          if (timer_q == 8'd0) begin
            next_q <= 1'b0;
            if (gap_q == 8'd0) begin
              state_q <= S_IDLE;
              busy_q  <= (count_d != '0);
            end else begin
              state_q <= S_GAP;
              timer_q <= gap_q - 8'd1;
            end
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        S_GAP: begin
          if (timer_q == 8'd0) begin
            state_q <= S_IDLE;
            busy_q  <= (count_d != '0);
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign success_o   = success_q;
  assign next_test_o = next_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_test_status_reporter.sv
// tb/tb_test_status_reporter.sv - Self-checking bench for test_status_reporter against a queue/timeline model.
module tb_test_status_reporter;

  localparam int DEPTH = 4;
  localparam int SETUP = 2;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0, wb_adr = 4'h0;
  logic [31:0] wb_dat = 32'h0;
  logic        wb_ack;
  logic [31:0] wb_rdat;
  logic        success, next_test, busy;

  test_status_reporter #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .DEFAULT_PULSE(8), .DEFAULT_GAP(16)
  ) dut (
    .wb_clk_i(wb_clk), .wb_rst_i(wb_rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_ack_o(wb_ack), .wb_dat_o(wb_rdat), .success_o(success),
    .next_test_o(next_test), .busy_o(busy)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending bus access, seen by the model on the edge that registers it.
  logic        p_valid = 1'b0, p_we = 1'b0;
  logic [3:0]  p_adr = 4'h0, p_sel = 4'h0;
  logic [31:0] p_dat = 32'h0;

  typedef struct {
    logic v;
    int   pop_n;
    int   plen;
  } exp_t;

  logic   m_q[$];
  exp_t   exp_q[$];
  int     m_n = 0;
  int     m_next_pop = 0;
  int     m_tc = 0, m_fc = 0;
  logic   m_ov = 1'b0, m_busy = 1'b0;
  int     m_pulse = 8, m_gap = 16;
  logic [31:0] m_rd_exp = 32'h0;

  function automatic logic [31:0] model_read(input logic [1:0] r, input int sz);
    case (r)
      2'd0: return {27'd0, m_ov, 3'(sz), m_busy};
      2'd1: return {16'(m_fc), 16'(m_tc)};
      2'd2: return {16'd0, 8'(m_gap), 8'(m_pulse)};
      default: return {31'd0, m_fc != 0};
    endcase
  endfunction

  task automatic model_loop();
    forever begin
      @(posedge wb_clk);
      m_n++;
      if (wb_rst) begin
        m_q.delete(); exp_q.delete();
        m_next_pop = 0; m_tc = 0; m_fc = 0; m_ov = 1'b0; m_busy = 1'b0;
        m_pulse = 8; m_gap = 16;
      end else begin
        int   sz0, peff;
        logic pop, clr, v;
        sz0 = m_q.size();
        pop = (sz0 > 0) && (m_n >= m_next_pop);
        if (p_valid) m_rd_exp = model_read(p_adr[3:2], sz0);
        clr = p_valid && p_we && (p_adr[3:2] == 2'd3) && p_sel[0] && p_dat[0];
        if (pop) begin
          v = m_q.pop_front();
          peff = (m_pulse == 0) ? 1 : m_pulse;
          exp_q.push_back('{v: v, pop_n: m_n, plen: peff});
          m_next_pop = m_n + 1 + SETUP + peff + m_gap;
          if (!clr) begin
            if (m_tc < 65535) m_tc++;
            if (!v && m_fc < 65535) m_fc++;
          end
        end
        if (clr) begin m_tc = 0; m_fc = 0; m_ov = 1'b0; end
        if (p_valid && p_we && p_adr[3:2] == 2'd0 && p_sel[0]) begin
          if (sz0 < DEPTH || pop) m_q.push_back(p_dat[0]);
          else m_ov = 1'b1;
        end
        if (p_valid && p_we && p_adr[3:2] == 2'd2) begin
          if (p_sel[0]) m_pulse = int'(p_dat[7:0]);
          if (p_sel[1]) m_gap = int'(p_dat[15:8]);
        end
        m_busy = (m_q.size() > 0) || (m_n < m_next_pop - 1);
      end
    end
  endtask

  task automatic monitor_loop();
    logic prev = 1'b0, s_rise = 1'b0;
    int   cnt = 0, plen = 0;
    exp_t e;
    forever begin
      @(negedge wb_clk);
      if (wb_rst) begin
        prev = 1'b0; cnt = 0;
      end else begin
        check_eq("busy", busy, m_busy);
        if (next_test && !prev) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_pulse", 1, 0);
            plen = 0;
          end else begin
            e = exp_q.pop_front();
            check_eq("success_at_rise", success, e.v);
            check_eq("setup_cycles", m_n - e.pop_n, SETUP);
            plen = e.plen;
          end
          s_rise = success;
          cnt = 1;
        end else if (next_test) begin
          check_eq("success_stable", success, s_rise);
          cnt++;
        end else if (prev) begin
          check_eq("pulse_len", cnt, plen);
        end
        prev = next_test;
      end
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd);
    if (wb_ack) begin @(posedge wb_clk); #1; end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat = dat;
    p_valid = 1'b1; p_we = we; p_adr = adr; p_sel = sel; p_dat = dat;
    @(posedge wb_clk); #1;
    p_valid = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check_eq("ack", wb_ack, 1'b1);
    rd = wb_rdat;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] rd;
    wb_xfer(1'b1, adr, sel, dat, rd);
  endtask

  task automatic wb_read_chk(input string tag, input logic [3:0] adr);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 4'hF, 32'h0, rd);
    check_eq(tag, rd, m_rd_exp);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && (busy || m_busy); i++) begin @(posedge wb_clk); #1; end
    if (i >= limit) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge wb_clk); #2;
    wb_rst = 1'b1;
    #1;
    check_eq("rst_next_test", next_test, 1'b0);
    check_eq("rst_success", success, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ack", wb_ack, 1'b0);
    @(posedge wb_clk); @(posedge wb_clk); #1;
    wb_rst = 1'b0;
  endtask

  initial begin
    fork
      model_loop();
      monitor_loop();
    join_none

    #2;
    check_eq("reset_success", success, 1'b0);
    check_eq("reset_next_test", next_test, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_ack", wb_ack, 1'b0);
    check_eq("reset_dat", wb_rdat, 32'h0);
    @(posedge wb_clk); @(posedge wb_clk); #1;
    wb_rst = 1'b0;

    wb_read_chk("config_default", 4'h8);
    check_eq("config_default_const", m_rd_exp, 32'h00001008);
    wb_read_chk("result_reset", 4'h0);
    check_eq("dat_idle_zero", wb_rdat, 32'h0);

    // Single pass result with default timing.
    wb_write(4'h0, 4'h1, 32'h1);
    wait_idle(200);
    wb_read_chk("counts_single", 4'h4);

    // Back-to-back burst overflows the FIFO on the sixth push.
    do_reset();
    wb_write(4'h0, 4'hF, 32'h1);
    wb_write(4'h0, 4'hF, 32'h0);
    wb_write(4'h0, 4'hF, 32'h1);
    wb_write(4'h0, 4'hF, 32'h0);
    wb_write(4'h0, 4'hF, 32'h1);
    wb_write(4'h0, 4'hF, 32'h1);
    wb_read_chk("result_overflow", 4'h0);
    wait_idle(1000);
    wb_read_chk("counts_burst", 4'h4);
    check_eq("counts_burst_const", m_rd_exp, 32'h00020005);

    // Zero pulse/gap: one-cycle strobe, straight back to idle.
    wb_write(4'h8, 4'h3, 32'h0);
    wb_write(4'h0, 4'h1, 32'h0);
    wait_idle(100);
    wb_read_chk("clear_any_fail", 4'hC);
    check_eq("any_fail_const", m_rd_exp, 32'h1);

    // Reset mid-pulse.
    wb_write(4'h8, 4'h3, 32'h0000_0408);
    wb_write(4'h0, 4'h1, 32'h1);
    begin
      int i;
      for (i = 0; i < 50 && !next_test; i++) begin @(posedge wb_clk); #1; end
      if (i >= 50) check_eq("pulse_timeout", 0, 1);
    end
    @(posedge wb_clk); #1;
    do_reset();
    wb_read_chk("result_after_rst", 4'h0);
    repeat (40) @(posedge wb_clk);
    #1;

    // Clear landing on the same edge as a pop.
    wb_write(4'h8, 4'h3, 32'h0000_0402);
    for (int k = 0; k < 7; k++) wb_write(4'h0, 4'h1, 32'(k & 1));
    begin
      int i;
      for (i = 0; i < 200 && m_n != m_next_pop - 1; i++) begin @(posedge wb_clk); #1; end
      if (i >= 200) check_eq("align_timeout", 0, 1);
    end
    wb_write(4'hC, 4'h1, 32'h1);
    wb_read_chk("counts_after_clear", 4'h4);
    check_eq("counts_after_clear_const", m_rd_exp, 32'h0);
    wb_read_chk("ovf_after_clear", 4'h0);
    wait_idle(500);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        wb_write(4'h0, ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF, $urandom);
      end else if (op == 5) begin
        logic [3:0] a;
        a = 4'($urandom_range(0, 3) << 2);
        wb_read_chk("rand_read", a);
      end else if (op == 6 && !busy && !m_busy) begin
        logic [31:0] d;
        d = {$urandom_range(0, 65535), 16'(($urandom_range(0, 6) << 8) | $urandom_range(0, 5))};
        wb_write(4'h8, 4'($urandom_range(0, 15)), d);
        wb_read_chk("rand_config", 4'h8);
      end else if (op == 7) begin
        wb_write(4'hC, 4'hF, 32'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(0, 20)) @(posedge wb_clk);
        #1;
      end
    end
    wait_idle(5000);
    wb_read_chk("final_counts", 4'h4);
    wb_read_chk("final_result", 4'h0);
    wb_read_chk("final_any_fail", 4'hC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
